// File: rtl/axis_pkt_gen_if.sv
// rtl/axis_pkt_gen_if.sv - meta stream bundle between a packet source and its sink
interface axis_pkt_gen_if #(
  parameter int DATA_W = 128,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4
);
  localparam int KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] data;
  logic [KEEP_W-1:0] keep;
  logic              vld;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdt;
  logic              sop;
  logic              eop;
  logic              rdy;

  modport master (output data, keep, vld, tid, tdt, sop, eop, input rdy);
  modport slave  (input data, keep, vld, tid, tdt, sop, eop, output rdy);
endinterface

// File: rtl/axis_pkt_gen.sv
// rtl/axis_pkt_gen.sv - command-driven meta stream packet source with seeded byte ramp
module axis_pkt_gen #(
  parameter int DATA_W = 128,
  parameter int KEEP_W = DATA_W / 8,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ID_W-1:0]   cmd_tid,
  input  logic [DEST_W-1:0] cmd_tdt,
  input  logic [7:0]        cmd_seed,
  axis_pkt_gen_if.master    tx_meta,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic              err_zero_len
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [LEN_W-1:0]  beat;
  logic [LEN_W-1:0]  last_beat;
  logic [KEEP_W-1:0] last_keep;
  logic [7:0]        base;

  logic [LEN_W-1:0]  cmd_last;
  logic [LEN_W-1:0]  cmd_rem;
  logic [KEEP_W-1:0] cmd_keep;
  logic [KEEP_W-1:0] first_keep;
  logic [LEN_W-1:0]  nxt_beat;
  logic [KEEP_W-1:0] nxt_keep;
  logic [7:0]        nxt_base;

  // Lane j of a beat carries base+j where enabled, zero past the packet end.
  function automatic logic [DATA_W-1:0] fill(input logic [7:0] b, input logic [KEEP_W-1:0] kp);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int j = 0; j < KEEP_W; j++) begin
      if (kp[j]) d[8*j +: 8] = b + 8'(j);
    end
    return d;
  endfunction

  always_comb begin
    cmd_last = (cmd_len - LEN_W'(1)) / LEN_W'(KEEP_W);
    cmd_rem  = cmd_len % LEN_W'(KEEP_W);
    cmd_keep = '0;
    for (int j = 0; j < KEEP_W; j++) begin
      cmd_keep[j] = (cmd_rem == '0) || (LEN_W'(j) < cmd_rem);
    end
    first_keep = (cmd_last == '0) ? cmd_keep : '1;
    nxt_beat   = beat + LEN_W'(1);
    nxt_keep   = (nxt_beat == last_beat) ? last_keep : '1;
    nxt_base   = base + 8'(KEEP_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cmd_rdy      <= 1'b0;
      busy         <= 1'b0;
      pkt_cnt      <= '0;
      err_zero_len <= 1'b0;
      beat         <= '0;
      last_beat    <= '0;
      last_keep    <= '0;
      base         <= '0;
      tx_meta.data <= '0;
      tx_meta.keep <= '0;
      tx_meta.vld  <= 1'b0;
      tx_meta.tid  <= '0;
      tx_meta.tdt  <= '0;
      tx_meta.sop  <= 1'b0;
      tx_meta.eop  <= 1'b0;
    end else begin
      err_zero_len <= 1'b0;
      case (state)
        IDLE: begin
          cmd_rdy <= 1'b1;
          if (cmd_rdy && cmd_vld) begin
            if (cmd_len == '0) begin
              err_zero_len <= 1'b1;
            end else begin
              state        <= SEND;
              cmd_rdy      <= 1'b0;
              busy         <= 1'b1;
              beat         <= '0;
              last_beat    <= cmd_last;
              last_keep    <= cmd_keep;
              base         <= cmd_seed;
              tx_meta.vld  <= 1'b1;
              tx_meta.sop  <= 1'b1;
              tx_meta.eop  <= (cmd_last == '0);
              tx_meta.tid  <= cmd_tid;
              tx_meta.tdt  <= cmd_tdt;
              tx_meta.keep <= first_keep;
              tx_meta.data <= fill(cmd_seed, first_keep);
            end
          end
        end
        SEND: begin
          if (tx_meta.vld && tx_meta.rdy) begin
            if (tx_meta.eop) begin
              state        <= IDLE;
              cmd_rdy      <= 1'b1;
              busy         <= 1'b0;
              pkt_cnt      <= pkt_cnt + CNT_W'(1);
              tx_meta.vld  <= 1'b0;
              tx_meta.sop  <= 1'b0;
              tx_meta.eop  <= 1'b0;
              tx_meta.tid  <= '0;
              tx_meta.tdt  <= '0;
              tx_meta.keep <= '0;
              tx_meta.data <= '0;
            end else begin
              beat         <= nxt_beat;
              base         <= nxt_base;
              tx_meta.sop  <= 1'b0;
              tx_meta.eop  <= (nxt_beat == last_beat);
              tx_meta.keep <= nxt_keep;
              tx_meta.data <= fill(nxt_base, nxt_keep);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb/tb_axis_pkt_gen.sv - scoreboard bench for axis_pkt_gen with randomized commands and backpressure
module tb_axis_pkt_gen;
  localparam int DATA_W = 128;
  localparam int KEEP_W = DATA_W / 8;
  localparam int ID_W   = 4;
  localparam int DEST_W = 4;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_vld = 1'b0;
  logic              cmd_rdy;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [ID_W-1:0]   cmd_tid = '0;
  logic [DEST_W-1:0] cmd_tdt = '0;
  logic [7:0]        cmd_seed = '0;
  logic              busy;
  logic [CNT_W-1:0]  pkt_cnt;
  logic              err_zero_len;

  always #5 clk = ~clk;

  axis_pkt_gen_if #(.DATA_W(DATA_W), .ID_W(ID_W), .DEST_W(DEST_W)) tx_meta ();

  axis_pkt_gen #(
    .DATA_W(DATA_W), .KEEP_W(KEEP_W), .ID_W(ID_W), .DEST_W(DEST_W),
    .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_vld(cmd_vld),
    .cmd_rdy(cmd_rdy),
    .cmd_len(cmd_len),
    .cmd_tid(cmd_tid),
    .cmd_tdt(cmd_tdt),
    .cmd_seed(cmd_seed),
    .tx_meta(tx_meta),
    .busy(busy),
    .pkt_cnt(pkt_cnt),
    .err_zero_len(err_zero_len)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdt;
    logic              sop;
    logic              eop;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests  = 0;
  int    n_fail   = 0;
  int    exp_cnt  = 0;
  int    hs_count = 0;
  bit    err_due  = 1'b0;
  bit    post_eop = 1'b0;
  int    rdy_mode = 0;
  int    pat_idx  = 0;
  bit    pat[6]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: packet byte i is (seed+i) mod 256, split into KEEP_W-byte beats.
  task automatic push_pkt(input int len, input int seed, input int tid, input int tdt);
    beat_t b;
    int nb;
    nb = (len + KEEP_W - 1) / KEEP_W;
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      b.keep = '0;
      for (int j = 0; j < KEEP_W; j++) begin
        int i;
        i = k * KEEP_W + j;
        if (i < len) begin
          b.data[8*j +: 8] = 8'((seed + i) % 256);
          b.keep[j] = 1'b1;
        end
      end
      b.tid = ID_W'(tid);
      b.tdt = DEST_W'(tdt);
      b.sop = (k == 0);
      b.eop = (k == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_cmd(input int len, input int seed, input int tid, input int tdt);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    cmd_vld  = 1'b1;
    cmd_len  = LEN_W'(len);
    cmd_seed = 8'(seed);
    cmd_tid  = ID_W'(tid);
    cmd_tdt  = DEST_W'(tdt);
    for (int t = 0; t < 20000 && !ok; t++) begin
      if (cmd_rdy) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("cmd_accept", ok, 1);
    if (ok) begin
      if (len == 0) err_due = 1'b1;
      else push_pkt(len, seed, tid, tdt);
    end
  endtask

  task automatic idle_cmd();
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 20000 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_meta.vld) done = 1'b1;
    end
    check("drain", done, 1);
    @(negedge clk);
  endtask

  // Backpressure: always ready, random, or a fixed pattern over valid cycles.
  initial begin
    tx_meta.rdy = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: tx_meta.rdy = 1'b1;
        1: tx_meta.rdy = ($urandom_range(0, 3) != 0);
        default: begin
          if (tx_meta.vld && pat_idx < 6) begin
            tx_meta.rdy = pat[pat_idx];
            pat_idx++;
          end else begin
            tx_meta.rdy = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: compares presented beats to the queue head, pops on handshake.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        post_eop = 1'b0;
        err_due  = 1'b0;
      end else begin
        if (post_eop) begin
          check("gap_vld", tx_meta.vld, 0);
          check("gap_cmd_rdy", cmd_rdy, 1);
          check("gap_pkt_cnt", pkt_cnt, CNT_W'(exp_cnt));
          post_eop = 1'b0;
        end
        check("err_zero_len", err_zero_len, err_due);
        err_due = 1'b0;
        if (tx_meta.vld) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", tx_meta.vld, 0);
          end else begin
            b = exp_q[0];
            check("data", tx_meta.data, b.data);
            check("keep", tx_meta.keep, b.keep);
            check("sop", tx_meta.sop, b.sop);
            check("eop", tx_meta.eop, b.eop);
            check("tid", tx_meta.tid, b.tid);
            check("tdt", tx_meta.tdt, b.tdt);
            check("busy_send", busy, 1);
            check("cmd_rdy_send", cmd_rdy, 0);
            check("pkt_cnt_send", pkt_cnt, CNT_W'(exp_cnt));
            if (tx_meta.rdy) begin
              void'(exp_q.pop_front());
              hs_count++;
              if (b.eop) begin
                exp_cnt++;
                post_eop = 1'b1;
              end
            end
          end
        end else begin
          check("busy_idle", busy, 0);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    int len;
    #1 rst = 1'b1;
    #2;
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_vld", tx_meta.vld, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_err", err_zero_len, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("rel_cmd_rdy", cmd_rdy, 1);

    send_cmd(16, 8'h00, 3, 5);
    idle_cmd();
    drain();
    check("t1_pkt_cnt", pkt_cnt, 1);

    send_cmd(37, 8'hFE, 1, 2);
    idle_cmd();
    drain();

    rdy_mode = 2;
    pat_idx  = 0;
    h0 = hs_count;
    send_cmd(48, 8'h40, 7, 9);
    idle_cmd();
    drain();
    check("t3_handshakes", hs_count - h0, 3);
    rdy_mode = 0;

    send_cmd(1, 8'h11, 2, 3);
    send_cmd(17, 8'h22, 4, 6);
    idle_cmd();
    drain();

    h0 = exp_cnt;
    send_cmd(0, 8'h33, 1, 1);
    idle_cmd();
    repeat (4) @(negedge clk);
    check("zero_len_pkt_cnt", pkt_cnt, CNT_W'(h0));

    send_cmd(65535, 8'h05, 15, 15);
    idle_cmd();
    drain();

    rdy_mode = 1;
    for (int n = 0; n < 30; n++) begin
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 200));
      send_cmd(len, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 0 || len == 0) idle_cmd();
    end
    idle_cmd();
    drain();
    rdy_mode = 0;

    send_cmd(80, 8'hA0, 5, 10);
    idle_cmd();
    for (int t = 0; t < 50 && exp_q.size() != 3; t++) @(negedge clk);
    check("rst_mid_at_beat2", exp_q.size(), 3);
    rst = 1'b1;
    #2;
    check("rst_mid_vld", tx_meta.vld, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_pkt_cnt", pkt_cnt, 0);
    check("rst_mid_cmd_rdy", cmd_rdy, 0);
    exp_q.delete();
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("rel2_cmd_rdy", cmd_rdy, 1);

    send_cmd(32, 8'h77, 9, 4);
    idle_cmd();
    drain();
    check("final_pkt_cnt", pkt_cnt, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
